// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: shift-and-add-3 binary-to-BCD converter shared by two round-robin requesters
module bcd_conv_arb #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [1:0]     i_req,
  input  logic [W-1:0]   i_bin0,
  input  logic [W-1:0]   i_bin1,
  output logic [1:0]     o_gnt,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_done_id,
  output logic [4*D-1:0] o_bcd
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   bin_q, bin_d, bin_sh;
  logic [4*D-1:0] work_q, work_d, work_adj, work_sh, bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           id_q, id_d, last_q, last_d, busy_q, busy_d, done_q, done_d, done_id_q, done_id_d;
  logic           win;
  genvar g;
  for (g = 0; g < D; g++) begin : g_adj
    assign work_adj[4*g+:4] = (work_q[4*g+:4] >= 4'd5) ? work_q[4*g+:4] + 4'd3 : work_q[4*g+:4];
  end
  assign {work_sh, bin_sh} = {work_adj[4*D-2:0], bin_q, 1'b0};
  // last_q names the requester served last; a tie goes to the other one
  assign win = (&i_req) ? ~last_q : i_req[1];
  // next-state: arbitrate and capture in IDLE, adjust-and-shift once per cycle in CONV
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    busy_d    = busy_q;
    bcd_d     = bcd_q;
    done_id_d = done_id_q;
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (|i_req) begin
        state_d = CONV;
        bin_d   = win ? i_bin1 : i_bin0;
        work_d  = '0;
        cnt_d   = '0;
        id_d    = win;
        gnt_d   = win ? 2'b10 : 2'b01;
        busy_d  = 1'b1;
      end
    end else begin
      bin_d  = bin_sh;
      work_d = work_sh;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_d == CW'(W)) begin
        state_d   = IDLE;
        bcd_d     = work_sh;
        done_id_d = id_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        last_d    = id_q;
      end
    end
  end
  // state and registered outputs; reset aborts any conversion in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      bcd_q     <= '0;
      done_id_q <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      bcd_q     <= bcd_d;
      done_id_q <= done_id_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
    end
  end
  assign o_gnt     = gnt_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_done_id = done_id_q;
  assign o_bcd     = bcd_q;
endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb_bcd_conv_arb: scoreboard bench for the shared binary-to-BCD converter
module tb_bcd_conv_arb;
  localparam int W = 8;
  localparam int D = 3;
  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [1:0]     i_req = 2'b00;
  logic [W-1:0]   i_bin0 = '0;
  logic [W-1:0]   i_bin1 = '0;
  logic [1:0]     o_gnt;
  logic           o_busy, o_done, o_done_id;
  logic [4*D-1:0] o_bcd;
  typedef struct packed {logic id; logic [4*D-1:0] bcd;} res_t;
  res_t       exp_res[$];
  logic [1:0] exp_gnt[$];
  int vec = 0, miss = 0, cyc = 0, gnt_cyc = 0, busy_run = 0;
  logic prev_done = 1'b0;

  bcd_conv_arb #(.W(W), .D(D)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_bin0(i_bin0), .i_bin1(i_bin1),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_done(o_done), .o_done_id(o_done_id), .o_bcd(o_bcd)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compares every grant and every result against the scoreboard queues
  always @(negedge i_clk) begin
    res_t r;
    cyc++;
    if (!i_rst_n) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (o_gnt != 2'b00) begin
        if (exp_gnt.size() == 0) begin
          vec++; miss++;
          $display("FAIL unexpected_gnt: got %b expected none", o_gnt);
        end else chk("gnt", {30'd0, o_gnt}, {30'd0, exp_gnt.pop_front()});
        gnt_cyc = cyc;
      end
      if (o_busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, W);
        busy_run = 0;
      end
      if (o_done) begin
        chk("done_width", {31'd0, prev_done}, 0);
        chk("done_latency", cyc - gnt_cyc, W);
        if (exp_res.size() == 0) begin
          vec++; miss++;
          $display("FAIL unexpected_done: got bcd %h expected none", o_bcd);
        end else begin
          r = exp_res.pop_front();
          chk("bcd", {20'd0, o_bcd}, {20'd0, r.bcd});
          chk("done_id", {31'd0, o_done_id}, {31'd0, r.id});
        end
      end
      prev_done = o_done;
    end
  end

  task automatic issue(input int k, input logic [W-1:0] v, input logic [4*D-1:0] e, input bit push);
    res_t r;
    if (k == 0) i_bin0 = v; else i_bin1 = v;
    i_req[k] = 1'b1;
    exp_gnt.push_back(k == 0 ? 2'b01 : 2'b10);
    r.id  = k[0];
    r.bcd = e;
    if (push) exp_res.push_back(r);
  endtask

  task automatic wait_gnt(input int k);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge i_clk); #1;
      got = o_gnt[k];
    end
    chk("gnt_wait", {31'd0, got}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_res.size() != 0; i++) @(negedge i_clk);
    chk("drain", exp_res.size(), 0);
    @(negedge i_clk);
  endtask

  initial begin
    logic [W-1:0]   vals [5] = '{8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    logic [4*D-1:0] bcds [5] = '{12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
    int c0;
    i_req = 2'b11;
    repeat (3) @(negedge i_clk);
    chk("rst_gnt", {30'd0, o_gnt}, 0);
    chk("rst_busy", {31'd0, o_busy}, 0);
    chk("rst_done", {31'd0, o_done}, 0);
    chk("rst_id", {31'd0, o_done_id}, 0);
    chk("rst_bcd", {20'd0, o_bcd}, 0);
    i_req = 2'b00;
    issue(0, 8'd0, 12'h000, 1);
    i_rst_n = 1'b1;
    wait_gnt(0);
    i_req[0] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      issue(0, vals[j], bcds[j], 1);
      wait_gnt(0);
      i_req[0] = 1'b0;
    end
    drain();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_bin0 = 8'd37;
    i_bin1 = 8'd142;
    for (int j = 0; j < 4; j++) begin
      res_t r;
      r.id  = j[0];
      r.bcd = j[0] ? 12'h142 : 12'h037;
      exp_gnt.push_back(j[0] ? 2'b10 : 2'b01);
      exp_res.push_back(r);
    end
    i_req = 2'b11;
    c0 = 0;
    for (int j = 0; j < 4; j++) begin
      wait_gnt(j % 2);
      if (j > 0) chk("rr_spacing", cyc - c0, W + 1);
      c0 = cyc;
    end
    i_req = 2'b00;
    drain();
    issue(0, 8'd50, 12'h050, 1);
    wait_gnt(0);
    i_req[0] = 1'b0;
    c0 = cyc;
    repeat (2) @(posedge i_clk);
    #1 issue(1, 8'd77, 12'h077, 1);
    wait_gnt(1);
    chk("busy_req_delay", cyc - c0, W + 1);
    i_req[1] = 1'b0;
    drain();
    issue(0, 8'd60, 12'h060, 1);
    wait_gnt(0);
    i_req[0] = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_bin1 = 8'd99;
    i_req[1] = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_req[1] = 1'b0;
    drain();
    repeat (3) begin
      @(negedge i_clk);
      chk("bcd_hold", {20'd0, o_bcd}, {20'd0, 12'h060});
    end
    issue(0, 8'd200, 12'h200, 0);
    wait_gnt(0);
    i_req[0] = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, o_busy}, 0);
    chk("abort_bcd", {20'd0, o_bcd}, 0);
    chk("abort_done", {31'd0, o_done}, 0);
    i_bin0 = 8'd5;
    i_bin1 = 8'd6;
    i_req  = 2'b11;
    issue(0, 8'd5, 12'h005, 1);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_gnt(0);
    i_req = 2'b00;
    drain();
    repeat (12) @(negedge i_clk);
    chk("queues_empty", exp_res.size() + exp_gnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bcd_conv_arb.md
# bcd_conv_arb

Sequential binary-to-BCD converter shared between two requesters. It uses the shift-and-add-3 algorithm and performs one shift per clock, so a single adjust stage is reused over W cycles instead of being unrolled W times. A round-robin arbiter grants the converter to one requester at a time. It sits between value producers in the PS/2 lab (for example, key count and scan/ASCII code) and the seven-segment display path.

## Interface
- W, 8, binary operand width in bits (W ≥ 1).
- D, 3, BCD output digits; must satisfy 10^D > 2^W − 1. Any other combination is unsupported.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_req  in  2  request per requester. Each requester holds its bit high, with its operand stable, until it sees its grant.
- i_bin0  in  W  operand from requester 0.
- i_bin1  in  W  operand from requester 1.
- o_gnt  out  2  one-hot, one-cycle pulse marking the requester whose operand was captured.
- o_busy  out  1  high while a conversion is in progress.
- o_done  out  1  one-cycle pulse; o_bcd is valid in this cycle.
- o_done_id  out  1  requester index of the result in o_bcd; held until the next o_done.
- o_bcd  out  4·D  packed BCD result, most significant digit in the top nibble; held until the next o_done.

## Operation
- FSM has two states: IDLE and CONV. Reset enters IDLE.
- Reset values: o_gnt=0, o_busy=0, o_done=0, o_done_id=0, o_bcd=0. The round-robin pointer resets so that requester 0 wins the first tie.
- **IDLE with any i_req bit high at an edge:**
  - Select a winner. A single requester always wins. If both request, the winner is the one not served last.
  - Capture the winner's operand into the shift register; clear the BCD work register; set cnt=0.
  - Set o_gnt[winner]=1 and o_busy=1; record winner id; state→CONV.
- **CONV, each edge:**
  - Every BCD work digit ≥ 5 gets +3, computed in 4 bits with no inter-digit carry.
  - Then {bcd_work, bin_shift} shifts left by 1; cnt increments; o_gnt returns to 0.
  - On the edge where cnt reaches W (the W-th shift): load o_bcd from the shifted work register, set o_done_id to the recorded id, o_done=1, o_busy=0, and advance the round-robin pointer past the winner. State→IDLE.
- **IDLE with no request:** o_done returns to 0 and o_bcd holds.
- i_req is ignored in CONV. Requests are not queued; a held request is served in a later IDLE. A request withdrawn before its grant is dropped without side effect.
- The round-robin pointer updates only on completion.

## Timing
- Capture edge E0: o_gnt and o_busy go high in the cycle after E0.
- Shift edges E1..EW. The result appears at EW: o_done=1 and the new o_bcd are visible in the cycle after EW, which is W cycles after the capture cycle.
- o_busy is high in the cycles after E0 through EW inclusive, i.e. W cycles.
- The next capture can occur at edge EW+1, so the done cycle overlaps the next IDLE decision.
- Sustained throughput is one conversion per W+1 cycles.
- Reset asserted mid-conversion:
  - All outputs return to reset values immediately (asynchronous).
  - No o_done is emitted for the aborted operand.
  - After release, arbitration restarts from the reset pointer.
- Maximum operand (2^W − 1) must convert without overflow. D is sized to guarantee this, so no saturation logic is needed.

## Test plan
- **Reset:** hold i_rst_n=0 with i_req=2'b11 → all outputs 0, no grant. Release and hold i_req=2'b01 with i_bin0=8'd0 → o_gnt=2'b01 one cycle after capture, o_done exactly 8 cycles after the capture cycle, o_bcd=12'h000, o_done_id=0.
- **Value corners (requester 0):** 8'd9→12'h009, 8'd10→12'h010, 8'd99→12'h099, 8'd100→12'h100, 8'd255→12'h255. For each, o_busy high for exactly 8 cycles and o_done high for exactly 1 cycle.
- **Round-robin:** i_req=2'b11 held continuously with i_bin0=8'd37, i_bin1=8'd142 → grants alternate 01,10,01,10. Results alternate 12'h037 (id 0) and 12'h142 (id 1). Each new capture occurs at the edge ending the done cycle.
- **Request during busy:** i_req[1] rises during requester 0's conversion and is held → ignored until completion, then granted at the next edge. A 2-cycle i_req[1] pulse that ends inside CONV → never granted, and o_bcd keeps its prior value.
- **Reset mid-conversion:** assert i_rst_n=0 at cycle 4 of a conversion of 8'd200 → o_busy and o_bcd drop to 0 asynchronously and no o_done appears. After release, with i_req=2'b11, requester 0 is granted first.
